cla_pipe_adder: RTL and testbench

- Two-stage pipelined carry-lookahead adder that registers its operands and produces a registered sum.
- It is the datapath stage that feeds the adder's storage flip-flops.
- Operands enter with a valid/ready handshake. Stage 1 computes and registers per-group propagate/generate. Stage 2 resolves group carries by lookahead and registers sum, carry-out and signed overflow.
- Backpressure from the consumer stalls the pipeline without dropping or duplicating any result.

---
 rtl/cla_pkg.sv | 15 +
 rtl/cla_group4.sv | 31 +++
 rtl/cla_pipe_adder.sv | 131 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int GROUP = 4;

    function automatic int ngroups(input int width);
        return width / GROUP;
    endfunction

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead cell: group propagate/generate and a 4-bit sum.
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output pg_t        pg,
    output logic [3:0] sum
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign pg.p = &p;
    assign pg.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);

    assign sum = p ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshakes.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = ngroups(WIDTH);

    logic adv1;
    logic adv2;

    logic             s1_valid;
    pg_t [NG-1:0]     s1_pg;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic             s1_cin;
    logic             s1_msbx;

    pg_t [NG-1:0]     pg_in;
    logic [WIDTH-1:0] pg_sum_unused;

    logic [NG:0]      gc;
    logic [NG:0]      gv;
    logic [NG:1]      pv;
    logic             prod;
    logic             acc;
    logic [WIDTH-1:0] sum_c;
    pg_t [NG-1:0]     pg2_unused;
    logic             ovf_c;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // Stage 2 rebuilds operands as (p|g, g): their xor is p and their and is g.
    for (genvar i = 0; i < NG; i++) begin : g_grp
        cla_group4 u_pg (
            .a   (a[i*GROUP +: GROUP]),
            .b   (b[i*GROUP +: GROUP]),
            .cin (1'b0),
            .pg  (pg_in[i]),
            .sum (pg_sum_unused[i*GROUP +: GROUP])
        );
        cla_group4 u_sum (
            .a   (s1_p[i*GROUP +: GROUP] | s1_g[i*GROUP +: GROUP]),
            .b   (s1_g[i*GROUP +: GROUP]),
            .cin (gc[i]),
            .pg  (pg2_unused[i]),
            .sum (sum_c[i*GROUP +: GROUP])
        );
    end

    always_comb begin
        gv    = '0;
        pv    = '0;
        gc    = '0;
        prod  = 1'b0;
        acc   = 1'b0;
        gv[0] = s1_cin;
        gc[0] = s1_cin;
        for (int i = 0; i < NG; i++) begin
            gv[i+1] = s1_pg[i].g;
            pv[i+1] = s1_pg[i].p;
        end
        // Flat sum of products per group carry; gv[0] carries cin.
        for (int i = 0; i < NG; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i + 1; j++) begin
                prod = gv[j];
                for (int k = j + 1; k <= i + 1; k++) begin
                    prod = prod & pv[k];
                end
                acc = acc | prod;
            end
            gc[i+1] = acc;
        end
    end

    assign ovf_c = (sum_c[WIDTH-1] ^ s1_msbx) ^ gc[NG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pg    <= '0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_cin   <= 1'b0;
            s1_msbx  <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_pg   <= pg_in;
                s1_p    <= a ^ b;
                s1_g    <= a & b;
                s1_cin  <= cin;
                s1_msbx <= a[WIDTH-1] ^ b[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_c;
                cout <= gc[NG];
                ovf  <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Randomized self-checking bench for cla_pipe_adder against an arithmetic model.
module tb_cla_pipe_adder;

    localparam int W = 8;

    typedef logic [W+1:0] res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    res_t obs;
    assign obs = {ovf, cout, sum};

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_add(input logic [W-1:0] x,
                                     input logic [W-1:0] y,
                                     input logic c);
        int   u;
        int   s;
        res_t r;
        u = int'(x) + int'(y) + int'(c);
        s = (x >= 8'd128 ? int'(x) - 256 : int'(x))
          + (y >= 8'd128 ? int'(y) - 256 : int'(y)) + int'(c);
        r[W-1:0] = u[W-1:0];
        r[W]     = (u > 255);
        r[W+1]   = (s > 127) || (s < -128);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic c,
                         input logic r);
        @(negedge clk);
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = c;
        out_ready = r;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, obs} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%h want v=0 r=0", out_valid, obs);
        end
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic one_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input string name);
        res_t e;
        e = ref_add(x, y, c);
        drive(1'b1, x, y, c, 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got %b want 1", name, in_ready);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: got out_valid=%b want 0", name, out_valid);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || obs !== e) begin
            errors++;
            $display("FAIL %s_result: got v=%b r=%h want v=1 r=%h", name, out_valid, obs, e);
        end
    endtask

    task automatic test_basic();
        one_op(8'h3C, 8'h29, 1'b0, "basic");
    endtask

    task automatic test_corners();
        one_op(8'hFF, 8'h00, 1'b1, "wrap");
        one_op(8'h7F, 8'h01, 1'b0, "pos_ovf");
        one_op(8'h80, 8'h80, 1'b0, "neg_ovf");
        one_op(8'hFF, 8'hFF, 1'b1, "all_ones");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xs[16];
        logic [W-1:0] ys[16];
        logic         cs[16];
        for (int i = 0; i < 16; i++) begin
            xs[i] = W'($urandom);
            ys[i] = W'($urandom);
            cs[i] = 1'($urandom);
        end
        for (int cyc = 0; cyc < 19; cyc++) begin
            if (cyc < 16) drive(1'b1, xs[cyc], ys[cyc], cs[cyc], 1'b1);
            else drive(1'b0, '0, '0, 1'b0, 1'b1);
            if (cyc < 16) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready cyc %0d: got %b want 1", cyc, in_ready);
                end
            end
            checks++;
            if (cyc >= 2 && cyc < 18) begin
                if (out_valid !== 1'b1 ||
                    obs !== ref_add(xs[cyc-2], ys[cyc-2], cs[cyc-2])) begin
                    errors++;
                    $display("FAIL stream_out cyc %0d: got v=%b r=%h want v=1 r=%h",
                             cyc, out_valid, obs, ref_add(xs[cyc-2], ys[cyc-2], cs[cyc-2]));
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_idle cyc %0d: got v=%b want 0", cyc, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] xs[3];
        logic [W-1:0] ys[3];
        logic         cs[3];
        res_t         e[3];
        res_t         held;
        for (int i = 0; i < 3; i++) begin
            xs[i] = W'($urandom);
            ys[i] = W'($urandom);
            cs[i] = 1'($urandom);
            e[i]  = ref_add(xs[i], ys[i], cs[i]);
        end
        drive(1'b1, xs[0], ys[0], cs[0], 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept1: got %b want 1", in_ready);
        end
        drive(1'b1, xs[1], ys[1], cs[1], 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept2: got %b want 1", in_ready);
        end
        drive(1'b1, xs[2], ys[2], cs[2], 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== e[0]) begin
            errors++;
            $display("FAIL bp_full: got rdy=%b v=%b r=%h want rdy=0 v=1 r=%h",
                     in_ready, out_valid, obs, e[0]);
        end
        held = obs;
        repeat (4) begin
            drive(1'b1, xs[2], ys[2], cs[2], 1'b0);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== held) begin
                errors++;
                $display("FAIL bp_hold: got rdy=%b v=%b r=%h want rdy=0 v=1 r=%h",
                         in_ready, out_valid, obs, held);
            end
        end
        drive(1'b1, xs[2], ys[2], cs[2], 1'b1);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || obs !== e[0]) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b v=%b r=%h want rdy=1 v=1 r=%h",
                     in_ready, out_valid, obs, e[0]);
        end
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            checks++;
            if (i < 3 && (out_valid !== 1'b1 || obs !== e[i])) begin
                errors++;
                $display("FAIL bp_drain%0d: got v=%b r=%h want v=1 r=%h",
                         i, out_valid, obs, e[i]);
            end else if (i == 3 && out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_empty: got v=%b want 0", out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        res_t e;
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        drive(1'b1, 8'h56, 8'h78, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, obs} !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: got v=%b r=%h want v=0 r=0", out_valid, obs);
        end
        #3 rst = 1'b0;
        repeat (3) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_nopulse: got v=%b want 0", out_valid);
            end
        end
        e = ref_add(8'hA5, 8'h5A, 1'b1);
        drive(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_latency: got v=%b want 0", out_valid);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || obs !== e) begin
            errors++;
            $display("FAIL rstmid_result: got v=%b r=%h want v=1 r=%h", out_valid, obs, e);
        end
    endtask

    task automatic test_random();
        res_t         q[$];
        res_t         held;
        res_t         want;
        logic [W-1:0] pa;
        logic [W-1:0] pb;
        logic         pc;
        logic         pv;
        logic         rdy;
        logic         hold_chk;
        pv = 1'b0; pa = '0; pb = '0; pc = 1'b0;
        hold_chk = 1'b0;
        held = '0;
        for (int n = 0; n < 10005; n++) begin
            if (n < 10000 && !pv && $urandom_range(0, 9) < 7) begin
                pa = W'($urandom);
                pb = W'($urandom);
                pc = 1'($urandom);
                pv = 1'b1;
            end
            rdy = (n >= 10000) || ($urandom_range(0, 9) < 6);
            drive(pv, pa, pb, pc, rdy);
            checks++;
            if (in_ready !== (q.size() < 2 || rdy)) begin
                errors++;
                $display("FAIL rnd_ready n=%0d: got %b want %b", n, in_ready,
                         (q.size() < 2 || rdy));
            end
            if (hold_chk) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    errors++;
                    $display("FAIL rnd_stable n=%0d: got v=%b r=%h want v=1 r=%h",
                             n, out_valid, obs, held);
                end
            end
            if (out_valid === 1'b1 && rdy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra n=%0d: got r=%h want no output", n, obs);
                end else begin
                    want = q.pop_front();
                    if (obs !== want) begin
                        errors++;
                        $display("FAIL rnd_data n=%0d: got %h want %h", n, obs, want);
                    end
                end
            end
            hold_chk = (out_valid === 1'b1) && !rdy;
            held = obs;
            if (pv && in_ready === 1'b1) begin
                q.push_back(ref_add(pa, pb, pc));
                pv = 1'b0;
            end
        end
        checks++;
        if (q.size() != 0 || pv) begin
            errors++;
            $display("FAIL rnd_drain: got %0d left want 0", q.size() + int'(pv));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
